aes_dec: RTL and testbench

Iterative AES-128 decryption core: expands a 128-bit cipher key into the eleven round keys once per `fsm_en` pulse, then decrypts one 128-bit block per `enable` pulse at one round per clock. It is the receive-side partner of the AES_enc encryptor. It sits directly on that encryptor's ciphertext output and shares its clock, reset and key.

---
 rtl/aes_dec.sv | 223 ++++++++++++++++++++++
 tb/tb_aes_dec.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_dec.sv
// Iterative AES-128 decryption core: expands KEY into eleven round keys on an
// fsm_en pulse, then decrypts one block per enable pulse at one round per clock.
module aes_dec (
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] IN,
  input  logic [127:0] KEY,
  input  logic         fsm_en,
  input  logic         enable,
  output logic [127:0] OUT
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_KEXP  = 2'd1,
    S_READY = 2'd2,
    S_RUN   = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [3:0]          r_cnt;
  logic [10:0][127:0]  r_rk;
  logic [127:0]        r_blk;
  logic [127:0]        r_out;
  logic [127:0]        w_rk_prev;
  logic [127:0]        w_rk_cur;
  logic [127:0]        w_rk_next;
  logic [127:0]        w_ark;
  logic [127:0]        w_imc;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      p = p ^ (x & {8{b[i]}});
      x = {x[6:0], 1'b0} ^ (8'h1b & {8{x[7]}});
    end
    return p;
  endfunction

  // x^254 is the multiplicative inverse in GF(2^8), and maps 0 to 0 as AES needs.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] r;
    logic [7:0] s;
    r = 8'h01;
    s = a;
    for (int k = 1; k < 8; k++) begin
      s = gf_mul(s, s);
      r = gf_mul(r, s);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    return (x << n) | (x >> (8 - n));
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] i;
    i = gf_inv(x);
    return i ^ rotl8(i, 1) ^ rotl8(i, 2) ^ rotl8(i, 3) ^ rotl8(i, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] x);
    return gf_inv(rotl8(x, 1) ^ rotl8(x, 3) ^ rotl8(x, 6) ^ 8'h05);
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] idx);
    logic [7:0] v;
    case (idx)
      4'd1:    v = 8'h01;
      4'd2:    v = 8'h02;
      4'd3:    v = 8'h04;
      4'd4:    v = 8'h08;
      4'd5:    v = 8'h10;
      4'd6:    v = 8'h20;
      4'd7:    v = 8'h40;
      4'd8:    v = 8'h80;
      4'd9:    v = 8'h1b;
      4'd10:   v = 8'h36;
      default: v = 8'h00;
    endcase
    return v;
  endfunction

  function automatic logic [127:0] key_step(input logic [127:0] prev, input logic [7:0] rc);
    logic [31:0] t;
    logic [31:0] w0;
    logic [31:0] w1;
    logic [31:0] w2;
    logic [31:0] w3;
    t  = {sbox(prev[23:16]), sbox(prev[15:8]), sbox(prev[7:0]), sbox(prev[31:24])}
         ^ {rc, 24'h000000};
    w0 = prev[127:96] ^ t;
    w1 = prev[95:64] ^ w0;
    w2 = prev[63:32] ^ w1;
    w3 = prev[31:0] ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  // Byte n of the block sits at bits [127-8n -: 8]; byte 4c+r is row r, column c.
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = 128'h0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127 - 8 * (4 * c + r) -: 8] = s[127 - 8 * (4 * ((c - r + 4) % 4) + r) -: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    o = 128'h0;
    for (int n = 0; n < 16; n++) begin
      o[127 - 8 * n -: 8] = inv_sbox(s[127 - 8 * n -: 8]);
    end
    return o;
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0;
    logic [7:0]   a1;
    logic [7:0]   a2;
    logic [7:0]   a3;
    o = 128'h0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127 - 32 * c -: 8];
      a1 = s[119 - 32 * c -: 8];
      a2 = s[111 - 32 * c -: 8];
      a3 = s[103 - 32 * c -: 8];
      o[127 - 32 * c -: 8] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
      o[119 - 32 * c -: 8] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
      o[111 - 32 * c -: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
      o[103 - 32 * c -: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
    end
    return o;
  endfunction

  // r_cnt names the key being produced in KEXP and the round key in use during RUN.
  always_comb begin
    w_rk_prev = 128'h0;
    w_rk_cur  = 128'h0;
    for (int i = 0; i < 11; i++) begin
      w_rk_prev = (r_cnt == 4'(i + 1)) ? r_rk[i] : w_rk_prev;
      w_rk_cur  = (r_cnt == 4'(i))     ? r_rk[i] : w_rk_cur;
    end
  end

  assign w_rk_next = key_step(w_rk_prev, rcon(r_cnt));
  assign w_ark     = inv_sub_bytes(inv_shift_rows(r_blk)) ^ w_rk_cur;
  assign w_imc     = inv_mix_columns(w_ark);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // fsm_en overrides everything, including a simultaneous enable.
  always_comb begin
    w_state_nxt = r_state;
    if (fsm_en) begin
      w_state_nxt = S_KEXP;
    end else begin
      case (r_state)
        S_KEXP:  w_state_nxt = (r_cnt == 4'd10) ? S_READY : S_KEXP;
        S_READY: w_state_nxt = enable ? S_RUN : S_READY;
        S_RUN:   w_state_nxt = (r_cnt == 4'd0) ? S_READY : S_RUN;
        default: w_state_nxt = r_state;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rk  <= '0;
      r_blk <= 128'h0;
      r_cnt <= 4'd0;
      r_out <= 128'h0;
    end else if (fsm_en) begin
      r_rk[0] <= KEY;
      r_cnt   <= 4'd1;
    end else begin
      case (r_state)
        S_KEXP: begin
          for (int i = 1; i < 11; i++) begin
            if (r_cnt == 4'(i)) begin
              r_rk[i] <= w_rk_next;
            end
          end
          r_cnt <= (r_cnt == 4'd10) ? 4'd0 : r_cnt + 4'd1;
        end
        S_READY: begin
          if (enable) begin
            r_blk <= IN ^ r_rk[10];
            r_cnt <= 4'd9;
          end
        end
        S_RUN: begin
          if (r_cnt != 4'd0) begin
            r_blk <= w_imc;
            r_cnt <= r_cnt - 4'd1;
          end else begin
            r_out <= w_ark;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign OUT = r_out;

endmodule

// File: tb/tb_aes_dec.sv
// Self-checking bench for aes_dec: FIPS-197 vectors plus random blocks produced by
// a forward AES-128 encryption model, with cycle-exact latency and overlap checks.
module tb_aes_dec;

  logic         clk;
  logic         rst;
  logic [127:0] IN;
  logic [127:0] KEY;
  logic         fsm_en;
  logic         enable;
  logic [127:0] OUT;

  int n_chk;
  int n_err;

  logic [7:0]   sb [256];
  logic [7:0]   sb_p;
  logic [7:0]   sb_q;
  logic [7:0]   sb_x;
  logic [127:0] exp_out;
  logic [127:0] key_a;
  logic [127:0] pt_a;
  logic [127:0] ct_a;
  logic [127:0] pt_b;
  logic [127:0] ct_b;

  aes_dec dut (
    .clk    (clk),
    .rst    (rst),
    .IN     (IN),
    .KEY    (KEY),
    .fsm_en (fsm_en),
    .enable (enable),
    .OUT    (OUT)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  function automatic logic [7:0] xt(input logic [7:0] v);
    return {v[6:0], 1'b0} ^ (v[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Forward AES-128 encryption (FIPS-197 Cipher), used as the reference.
  function automatic logic [127:0] enc(input logic [127:0] key, input logic [127:0] pt);
    logic [31:0]  w [44];
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [31:0]  tmp;
    logic [7:0]   rc;
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] o;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32 * i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      tmp = w[i - 1];
      if (i % 4 == 0) begin
        tmp = {sb[tmp[23:16]], sb[tmp[15:8]], sb[tmp[7:0]], sb[tmp[31:24]]} ^ {rc, 24'h000000};
        rc  = xt(rc);
      end
      w[i] = w[i - 4] ^ tmp;
    end
    for (int i = 0; i < 16; i++) s[i] = pt[127 - 8 * i -: 8] ^ w[i / 4][31 - 8 * (i % 4) -: 8];
    for (int rnd = 1; rnd <= 10; rnd++) begin
      for (int i = 0; i < 16; i++) t[i] = sb[s[i]];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) s[4 * c + r] = t[4 * ((c + r) % 4) + r];
      if (rnd < 10) begin
        for (int c = 0; c < 4; c++) begin
          a0 = s[4 * c]; a1 = s[4 * c + 1]; a2 = s[4 * c + 2]; a3 = s[4 * c + 3];
          s[4 * c]     = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
          s[4 * c + 1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
          s[4 * c + 2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
          s[4 * c + 3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
        end
      end
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[4 * rnd + i / 4][31 - 8 * (i % 4) -: 8];
    end
    o = 128'h0;
    for (int i = 0; i < 16; i++) o[127 - 8 * i -: 8] = s[i];
    return o;
  endfunction

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // fsm_en sampled at edge K; returns at the falling edge after K+10.
  task automatic kexp(input logic [127:0] key);
    KEY    = key;
    fsm_en = 1'b1;
    step();
    fsm_en = 1'b0;
    KEY    = rnd128();
    repeat (10) step();
  endtask

  // enable sampled at edge T; OUT must keep its old value through T+9 and update at T+10.
  task automatic decrypt(input string tag, input logic [127:0] ct, input logic [127:0] pt,
                         input logic [127:0] prev);
    IN     = ct;
    enable = 1'b1;
    step();
    enable = 1'b0;
    IN     = rnd128();
    repeat (9) step();
    chk({tag, "_early"}, OUT, prev);
    step();
    chk(tag, OUT, pt);
  endtask

  initial begin
    n_chk  = 0;
    n_err  = 0;
    rst    = 1'b0;
    IN     = 128'h0;
    KEY    = 128'h0;
    fsm_en = 1'b0;
    enable = 1'b0;

    // S-box built from generator-3 walk over GF(2^8) with the affine map.
    sb_p = 8'h01;
    sb_q = 8'h01;
    do begin
      sb_p = sb_p ^ xt(sb_p);
      sb_q = sb_q ^ {sb_q[6:0], 1'b0};
      sb_q = sb_q ^ {sb_q[5:0], 2'b00};
      sb_q = sb_q ^ {sb_q[3:0], 4'b0000};
      sb_q = sb_q ^ (sb_q[7] ? 8'h09 : 8'h00);
      sb_x = sb_q ^ rotl8(sb_q, 1) ^ rotl8(sb_q, 2) ^ rotl8(sb_q, 3) ^ rotl8(sb_q, 4);
      sb[sb_p] = sb_x ^ 8'h63;
    end while (sb_p != 8'h01);
    sb[0] = 8'h63;

    repeat (2) step();
    chk("reset_out", OUT, 128'h0);
    rst = 1'b1;
    step();

    IN     = rnd128();
    enable = 1'b1;
    step();
    enable = 1'b0;
    repeat (12) step();
    chk("enable_no_keys", OUT, 128'h0);

    // Expansion with an enable at K+10, one edge too early to be accepted.
    KEY    = 128'h000102030405060708090a0b0c0d0e0f;
    fsm_en = 1'b1;
    step();
    fsm_en = 1'b0;
    KEY    = rnd128();
    repeat (9) step();
    IN     = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    enable = 1'b1;
    step();
    enable = 1'b0;
    repeat (12) step();
    chk("enable_k10_ignored", OUT, 128'h0);

    decrypt("fips_c1", 128'h69c4e0d86a7b0430d8cdb78070b4c55a,
            128'h00112233445566778899aabbccddeeff, 128'h0);
    exp_out = 128'h00112233445566778899aabbccddeeff;

    ct_a = enc(128'h000102030405060708090a0b0c0d0e0f, 128'h00112233445566778899aabbccddeeff);
    chk("model_enc_c1", ct_a, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
    kexp(128'h000102030405060708090a0b0c0d0e0f);
    decrypt("chained", ct_a, 128'h00112233445566778899aabbccddeeff, exp_out);

    kexp(128'h2b7e151628aed2a6abf7158809cf4f3c);
    decrypt("key_change", 128'h3925841d02dc09fbdc118597196a0b32,
            128'h3243f6a8885a308d313198a2e0370734, exp_out);
    exp_out = 128'h3243f6a8885a308d313198a2e0370734;

    for (int n = 0; n < 6; n++) begin
      key_a = rnd128();
      pt_a  = rnd128();
      kexp(key_a);
      decrypt($sformatf("rand%0d", n), enc(key_a, pt_a), pt_a, exp_out);
      exp_out = pt_a;
      pt_b = rnd128();
      decrypt($sformatf("rand%0d_b2b", n), enc(key_a, pt_b), pt_b, exp_out);
      exp_out = pt_b;
    end

    // enable during RUN is dropped; only the first block reaches OUT.
    pt_a   = rnd128();
    pt_b   = rnd128();
    ct_a   = enc(key_a, pt_a);
    ct_b   = enc(key_a, pt_b);
    IN     = ct_a;
    enable = 1'b1;
    step();
    enable = 1'b0;
    repeat (3) step();
    IN     = ct_b;
    enable = 1'b1;
    step();
    enable = 1'b0;
    repeat (5) step();
    chk("overlap_early", OUT, exp_out);
    step();
    chk("overlap_first", OUT, pt_a);
    repeat (12) step();
    chk("overlap_second_dropped", OUT, pt_a);
    exp_out = pt_a;

    // fsm_en mid-RUN aborts the block without touching OUT.
    IN     = ct_b;
    enable = 1'b1;
    step();
    enable = 1'b0;
    repeat (4) step();
    kexp(key_a);
    repeat (2) step();
    chk("fsm_en_mid_run", OUT, exp_out);
    decrypt("after_abort", ct_b, pt_b, exp_out);
    exp_out = pt_b;

    // fsm_en and enable on the same edge: expansion wins, no block starts.
    IN     = ct_a;
    KEY    = key_a;
    enable = 1'b1;
    fsm_en = 1'b1;
    step();
    enable = 1'b0;
    fsm_en = 1'b0;
    repeat (12) step();
    chk("fsm_en_wins", OUT, exp_out);
    decrypt("after_tie", ct_a, pt_a, exp_out);

    // Asynchronous reset between edges, mid-decryption.
    IN     = ct_b;
    enable = 1'b1;
    step();
    enable = 1'b0;
    repeat (5) step();
    #2;
    rst = 1'b0;
    #1;
    chk("async_reset_out", OUT, 128'h0);
    repeat (2) step();
    rst = 1'b1;
    step();
    IN     = ct_b;
    enable = 1'b1;
    step();
    enable = 1'b0;
    repeat (12) step();
    chk("enable_after_reset", OUT, 128'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
